// File: rtl/branch_resolve_bht_if.sv
// Fetch/execute/resolution signal bundle for the branch resolve unit.
// The master side drives the stage inputs; the slave side is the branch unit.
interface branch_resolve_bht_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  i_pred_pc;
    logic             o_pred_taken;
    logic             i_valid;
    logic             i_flush;
    logic [XLEN-1:0]  i_pc;
    logic [XLEN-1:0]  i_dat_a;
    logic [XLEN-1:0]  i_dat_b;
    logic [2:0]       i_funct3;
    logic             i_branch;
    logic             i_jump;
    logic             i_pred_taken;
    logic             o_valid;
    logic             o_br_en;
    logic             o_mispredict;
    logic [CNT_W-1:0] o_br_count;
    logic [CNT_W-1:0] o_miss_count;

    modport master (
        output i_pred_pc, i_valid, i_flush, i_pc, i_dat_a, i_dat_b,
               i_funct3, i_branch, i_jump, i_pred_taken,
        input  o_pred_taken, o_valid, o_br_en, o_mispredict,
               o_br_count, o_miss_count
    );

    modport slave (
        input  i_pred_pc, i_valid, i_flush, i_pc, i_dat_a, i_dat_b,
               i_funct3, i_branch, i_jump, i_pred_taken,
        output o_pred_taken, o_valid, o_br_en, o_mispredict,
               o_br_count, o_miss_count
    );
endinterface

// File: rtl/branch_resolve_bht.sv
// Branch condition evaluation, one-cycle resolution register, 2-bit saturating
// BHT for fetch prediction, and saturating branch/mispredict event counters.
module branch_resolve_bht #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int PC_LSB    = 2,
    parameter int CNT_W     = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    branch_resolve_bht_if.slave    bus
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [IDX_W-1:0] w_pred_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic             w_eq;
    logic             w_lt_s;
    logic             w_lt_u;
    logic             w_cond;
    logic             w_act;
    logic             w_taken;
    logic             w_upd;
    logic             w_miss;
    logic [1:0]       w_bht [BHT_DEPTH];

    logic             r_valid;
    logic             r_br_en;
    logic             r_mispredict;
    logic [CNT_W-1:0] r_br_count;
    logic [CNT_W-1:0] r_miss_count;

    assign w_pred_idx = bus.i_pred_pc[PC_LSB +: IDX_W];
    assign w_ex_idx   = bus.i_pc[PC_LSB +: IDX_W];

    assign w_eq   = (bus.i_dat_a == bus.i_dat_b);
    assign w_lt_s = ($signed(bus.i_dat_a) < $signed(bus.i_dat_b));
    assign w_lt_u = (bus.i_dat_a < bus.i_dat_b);

    // funct3[2:1]=01 is reserved: never taken, and the invert bit is ignored.
    always_comb begin
        w_cond = 1'b0;
        case (bus.i_funct3[2:1])
            2'b00:   w_cond = w_eq   ^ bus.i_funct3[0];
            2'b10:   w_cond = w_lt_s ^ bus.i_funct3[0];
            2'b11:   w_cond = w_lt_u ^ bus.i_funct3[0];
            default: w_cond = 1'b0;
        endcase
    end

    assign w_act   = bus.i_valid & ~bus.i_flush;
    assign w_taken = bus.i_jump | (bus.i_branch & w_cond);
    assign w_upd   = w_act & bus.i_branch & ~bus.i_jump;
    assign w_miss  = w_act & (w_taken != bus.i_pred_taken);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid      <= 1'b0;
            r_br_en      <= 1'b0;
            r_mispredict <= 1'b0;
            r_br_count   <= '0;
            r_miss_count <= '0;
        end else begin
            r_valid      <= w_act;
            r_br_en      <= w_act & w_taken;
            r_mispredict <= w_miss;
            if (w_upd && (r_br_count != {CNT_W{1'b1}}))
                r_br_count <= r_br_count + CNT_W'(1);
            if (w_miss && (r_miss_count != {CNT_W{1'b1}}))
                r_miss_count <= r_miss_count + CNT_W'(1);
        end
    end

    // Each counter owns its register so the whole table can reset asynchronously.
    genvar gi;
    generate
        for (gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
            logic [1:0] r_cnt;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_cnt <= 2'b01;
                end else if (w_upd && (w_ex_idx == IDX_W'(gi))) begin
                    if (w_taken) begin
                        if (r_cnt != 2'b11)
                            r_cnt <= r_cnt + 2'd1;
                    end else if (r_cnt != 2'b00) begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
            end
            assign w_bht[gi] = r_cnt;
        end
    endgenerate

    // Read path sees the stored value, so a same-cycle update shows next cycle.
    assign bus.o_pred_taken = w_bht[w_pred_idx][1];
    assign bus.o_valid      = r_valid;
    assign bus.o_br_en      = r_br_en;
    assign bus.o_mispredict = r_mispredict;
    assign bus.o_br_count   = r_br_count;
    assign bus.o_miss_count = r_miss_count;
endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed test of branch_resolve_bht with 4-bit performance counters.
module tb_branch_resolve_bht;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    branch_resolve_bht_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    branch_resolve_bht #(
        .XLEN(XLEN), .BHT_DEPTH(64), .PC_LSB(2), .CNT_W(CNT_W)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.i_valid      = 1'b0;
        bus.i_flush      = 1'b0;
        bus.i_branch     = 1'b0;
        bus.i_jump       = 1'b0;
        bus.i_pred_taken = 1'b0;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic br, input logic jmp,
                         input logic pred, input logic flsh);
        bus.i_pc         = pc;
        bus.i_dat_a      = a;
        bus.i_dat_b      = b;
        bus.i_funct3     = f3;
        bus.i_branch     = br;
        bus.i_jump       = jmp;
        bus.i_pred_taken = pred;
        bus.i_flush      = flsh;
        bus.i_valid      = 1'b1;
    endtask

    // One execute-stage op; returns #1 after the resolving edge with inputs idled.
    task automatic exec(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f3, input logic br, input logic jmp,
                        input logic pred, input logic flsh);
        drive(pc, a, b, f3, br, jmp, pred, flsh);
        @(posedge clk);
        #1;
        idle_inputs();
        $display("op pc=%h a=%h b=%h f3=%b br=%b j=%b pred=%b fl=%b -> v=%b en=%b mp=%b brc=%0d mc=%0d",
                 pc, a, b, f3, br, jmp, pred, flsh, bus.o_valid, bus.o_br_en,
                 bus.o_mispredict, bus.o_br_count, bus.o_miss_count);
    endtask

    task automatic pred_at(input logic [31:0] pc, input logic exp, input string tag);
        bus.i_pred_pc = pc;
        #1;
        check(tag, 32'(bus.o_pred_taken), 32'(exp));
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        idle_inputs();
        bus.i_pc      = '0;
        bus.i_dat_a   = '0;
        bus.i_dat_b   = '0;
        bus.i_funct3  = '0;
        bus.i_pred_pc = 32'h100;
        #12;
        rst = 1'b0;
        #1;
        check("rst_valid",  32'(bus.o_valid), 32'd0);
        check("rst_br_en",  32'(bus.o_br_en), 32'd0);
        check("rst_misp",   32'(bus.o_mispredict), 32'd0);
        check("rst_brc",    32'(bus.o_br_count), 32'd0);
        check("rst_mc",     32'(bus.o_miss_count), 32'd0);
        pred_at(32'h100, 1'b0, "rst_pred");

        // BEQ taken at 0x100, predicted not-taken.
        exec(32'h100, 32'd5, 32'd5, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        check("beq_valid", 32'(bus.o_valid), 32'd1);
        check("beq_en",    32'(bus.o_br_en), 32'd1);
        check("beq_misp",  32'(bus.o_mispredict), 32'd1);
        check("beq_brc",   32'(bus.o_br_count), 32'd1);
        check("beq_mc",    32'(bus.o_miss_count), 32'd1);
        pred_at(32'h100, 1'b1, "beq_pred");

        // Signed vs unsigned, a=-1, b=1.
        exec(32'h100, 32'hFFFF_FFFF, 32'd1, 3'b100, 1'b1, 1'b0, 1'b1, 1'b0);
        check("blt_en",   32'(bus.o_br_en), 32'd1);
        check("blt_misp", 32'(bus.o_mispredict), 32'd0);
        exec(32'h100, 32'hFFFF_FFFF, 32'd1, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0);
        check("bltu_en",   32'(bus.o_br_en), 32'd0);
        check("bltu_misp", 32'(bus.o_mispredict), 32'd0);
        exec(32'h100, 32'hFFFF_FFFF, 32'd1, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
        check("bgeu_en",   32'(bus.o_br_en), 32'd1);
        check("bgeu_misp", 32'(bus.o_mispredict), 32'd1);
        check("sgn_brc",   32'(bus.o_br_count), 32'd4);
        check("sgn_mc",    32'(bus.o_miss_count), 32'd2);

        // Asynchronous reset between edges while a result is being shown.
        rst = 1'b1;
        #1;
        $display("async reset asserted: v=%b en=%b brc=%0d mc=%0d",
                 bus.o_valid, bus.o_br_en, bus.o_br_count, bus.o_miss_count);
        check("arst_valid", 32'(bus.o_valid), 32'd0);
        check("arst_en",    32'(bus.o_br_en), 32'd0);
        check("arst_misp",  32'(bus.o_mispredict), 32'd0);
        check("arst_brc",   32'(bus.o_br_count), 32'd0);
        check("arst_mc",    32'(bus.o_miss_count), 32'd0);
        pred_at(32'h100, 1'b0, "arst_pred");
        rst = 1'b0;

        // Saturation at pc 0x40: 4 taken, then not-taken down to 00, then taken back.
        for (int i = 0; i < 4; i++)
            exec(32'h40, 32'd7, 32'd7, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        pred_at(32'h40, 1'b1, "sat_hi_pred");
        exec(32'h40, 32'd7, 32'd7, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        check("bne_en", 32'(bus.o_br_en), 32'd0);
        pred_at(32'h40, 1'b1, "sat_10_pred");
        exec(32'h40, 32'd7, 32'd7, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        pred_at(32'h40, 1'b0, "sat_01_pred");
        exec(32'h40, 32'd7, 32'd7, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        exec(32'h40, 32'd7, 32'd7, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        exec(32'h40, 32'd7, 32'd7, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        pred_at(32'h40, 1'b0, "sat_lo_pred");
        exec(32'h40, 32'd7, 32'd7, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        pred_at(32'h40, 1'b1, "sat_up_pred");
        check("sat_brc", 32'(bus.o_br_count), 32'd10);
        check("sat_mc",  32'(bus.o_miss_count), 32'd6);
        // Aliasing PC with same index bits shares the counter.
        pred_at(32'h1040, 1'b1, "alias_pred");

        // Read/write collision at 0x80.
        bus.i_pred_pc = 32'h80;
        drive(32'h80, 32'd3, 32'd3, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("coll_pre", 32'(bus.o_pred_taken), 32'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        check("coll_post", 32'(bus.o_pred_taken), 32'd1);
        check("coll_brc",  32'(bus.o_br_count), 32'd11);
        check("coll_mc",   32'(bus.o_miss_count), 32'd7);

        // Flushed taken branch at 0xC0: nothing changes.
        exec(32'hC0, 32'd1, 32'd1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
        check("fl_valid", 32'(bus.o_valid), 32'd0);
        check("fl_en",    32'(bus.o_br_en), 32'd0);
        check("fl_misp",  32'(bus.o_mispredict), 32'd0);
        check("fl_brc",   32'(bus.o_br_count), 32'd11);
        check("fl_mc",    32'(bus.o_miss_count), 32'd7);
        pred_at(32'hC0, 1'b0, "fl_pred");

        // Jump (with branch also high) at 0xC0: taken, mispredicted, BHT untouched.
        exec(32'hC0, 32'd1, 32'd2, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
        check("jmp_en",   32'(bus.o_br_en), 32'd1);
        check("jmp_misp", 32'(bus.o_mispredict), 32'd1);
        check("jmp_brc",  32'(bus.o_br_count), 32'd11);
        check("jmp_mc",   32'(bus.o_miss_count), 32'd8);
        pred_at(32'hC0, 1'b0, "jmp_pred");

        // Reserved funct3 values never take and are not inverted.
        exec(32'h80, 32'd1, 32'd2, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0);
        check("r011_en",   32'(bus.o_br_en), 32'd0);
        check("r011_misp", 32'(bus.o_mispredict), 32'd0);
        pred_at(32'h80, 1'b0, "r011_pred");
        exec(32'h80, 32'd1, 32'd2, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0);
        check("r010_en",   32'(bus.o_br_en), 32'd0);
        check("r010_misp", 32'(bus.o_mispredict), 32'd1);
        check("r010_brc",  32'(bus.o_br_count), 32'd13);
        check("r010_mc",   32'(bus.o_miss_count), 32'd9);

        // Non-branch predicted taken is a mispredict.
        exec(32'h200, 32'd0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        check("nb_valid", 32'(bus.o_valid), 32'd1);
        check("nb_en",    32'(bus.o_br_en), 32'd0);
        check("nb_misp",  32'(bus.o_mispredict), 32'd1);
        check("nb_brc",   32'(bus.o_br_count), 32'd13);
        check("nb_mc",    32'(bus.o_miss_count), 32'd10);

        // Branch counter saturates at 15.
        for (int i = 0; i < 8; i++)
            exec(32'h100, 32'd9, 32'd9, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
        check("csat_brc", 32'(bus.o_br_count), 32'd15);
        check("csat_mc",  32'(bus.o_miss_count), 32'd10);

        @(posedge clk);
        #1;
        check("idle_valid", 32'(bus.o_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_resolve_bht.md
Name: branch_resolve_bht

Overview:
- Next-generation branch unit: parametrised-width branch condition evaluation, a registered resolution stage, and a 2-bit saturating-counter branch history table (BHT) for fetch-side prediction.
- Fetch reads a prediction combinationally. Execute presents the resolved operands plus the prediction carried down the pipe. One cycle later the block reports taken/mispredict and trains the BHT.
- Also provides saturating branch and mispredict event counters for performance monitoring.

Parameters:
- XLEN, 32, operand width in bits (≥8).
- BHT_DEPTH, 64, number of 2-bit counters; power of 2, 2..1024.
- PC_LSB, 2, lowest PC bit used for BHT indexing; the index is pc[PC_LSB +: log2(BHT_DEPTH)].
- CNT_W, 32, width of the performance counters.

Ports:
- i_clk  in  1  clock; all state changes on its rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_pred_pc  in  XLEN  fetch PC to predict.
- o_pred_taken  out  1  combinational prediction for i_pred_pc: the MSB of the indexed counter.
- i_valid  in  1  execute-stage instruction valid.
- i_flush  in  1  kill the execute-stage instruction this cycle.
- i_pc  in  XLEN  PC of the execute-stage instruction.
- i_dat_a  in  XLEN  comparator operand A.
- i_dat_b  in  XLEN  comparator operand B.
- i_funct3  in  3  branch condition selector.
- i_branch  in  1  conditional branch.
- i_jump  in  1  unconditional jump.
- i_pred_taken  in  1  prediction the fetch stage made for this instruction.
- o_valid  out  1  resolution result valid (registered).
- o_br_en  out  1  branch/jump taken (registered).
- o_mispredict  out  1  prediction was wrong (registered).
- o_br_count  out  CNT_W  resolved conditional branches, saturating.
- o_miss_count  out  CNT_W  mispredicts, saturating.

Behaviour:
- Reset (async, i_rst=1):
  - o_valid, o_br_en, o_mispredict and both counters are cleared to 0.
  - Every BHT entry is set to 2'b01 (weakly not-taken), so o_pred_taken=0 for any PC immediately.
- Condition: computed from funct3[2:1] with invert bit funct3[0].
  - funct3[2:1]=00 selects equal; 10 selects signed less-than; 11 selects unsigned less-than. The condition is the selected result XOR funct3[0].
  - funct3[2:1]=01 (010/011) is reserved: the condition is 0 and is NOT inverted.
  - All comparisons use the full XLEN bits.
- Active cycle: act = i_valid & ~i_flush.
- Taken: taken = i_jump | (i_branch & cond). If i_jump and i_branch are both high, the jump wins (taken=1).
- Resolution register: latency is exactly 1 cycle. At the edge, the block latches:
  - o_valid <= act
  - o_br_en <= act & taken
  - o_mispredict <= act & (taken != i_pred_taken)
  - A non-branch instruction with i_pred_taken=1 therefore reports a mispredict.
- BHT update: on the edge of any cycle with act & i_branch & ~i_jump, the counter at idx(i_pc) is updated.
  - If taken, it increments, saturating at 11; otherwise it decrements, saturating at 00.
  - Jumps and non-branches never modify the BHT.
- Read/write collision: when idx(i_pred_pc) == idx(i_pc) in an update cycle, o_pred_taken shows the pre-update value. The new value is visible from the next cycle.
- Performance counters:
  - o_br_count increments on the same edge as each BHT update.
  - o_miss_count increments when act & (taken != i_pred_taken).
  - Both saturate at all-ones and never wrap.
- Flush: i_flush=1 suppresses the BHT update, both counter increments, and o_valid in the following cycle, regardless of the other inputs.
- Reset mid-operation: takes effect immediately and asynchronously. Any in-flight resolution is lost; no partial BHT update is allowed.
- Indexing: PC bits above and below the index field are ignored, so aliasing PCs share one counter.

Test Plan:
- Reset then i_pred_pc=0x100 -> o_pred_taken=0. Branch at pc=0x100, funct3=000, a=b=5, pred=0 -> next cycle o_valid=1, o_br_en=1, o_mispredict=1, o_br_count=1, o_miss_count=1. The entry becomes 10 and o_pred_taken=1 at 0x100.
- Signed vs unsigned at XLEN=32: a=0xFFFFFFFF, b=1. funct3=100 -> taken=1; funct3=110 -> taken=0; funct3=111 -> taken=1.
- Saturation: four taken updates at pc=0x40 -> entry 11. One not-taken update -> entry 10, so o_pred_taken is still 1. Three more not-taken updates -> entry 00, and it stays at 00.
- Collision: i_pred_pc=i_pc=0x80 with the entry at 01, resolving a taken branch -> o_pred_taken=0 that cycle and 1 the next cycle.
- Flush/jump/reserved:
  - i_flush=1 with a taken branch -> o_valid=0, BHT and counters unchanged.
  - i_jump=1, pred=0 -> o_br_en=1, o_mispredict=1, BHT unchanged.
  - funct3=011 branch -> taken=0.
- Counter saturation and async reset: with CNT_W=4, 20 branches -> o_br_count holds at 15. Asserting i_rst between clock edges clears all outputs immediately and returns the BHT to 01.
